// File: rtl/instr_queue_if.sv
// Interface bundling the instruction-memory fetch port and the issue-side port of instr_queue.
// The queue uses the master modport. The memory and issue stage use the slave modport.
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  logic [31:0]             imem_addr;
  logic                    imem_req;
  logic [31:0]             imem_data;
  logic [31:0]             instruction;
  logic [31:0]             instr_pc;
  logic                    instr_valid;
  logic                    stall;
  logic                    flush;
  logic [31:0]             redirect_pc;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;

  modport master (
    output imem_addr, imem_req, instruction, instr_pc, instr_valid, count, full,
    input  imem_data, stall, flush, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_req, instruction, instr_pc, instr_valid, count, full,
    output imem_data, stall, flush, redirect_pc
  );
endinterface

// File: rtl/instr_queue.sv
// Instruction fetch queue: fetches sequential PCs from a synchronous instruction memory into a
// circular FIFO and presents the head to issue. A flush squashes the queue and redirects the PC.
module instr_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_queue_if.master  qif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic [31:0]      pc_q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_r;
  logic             req_q;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic [CNT_W:0]   pending;
  logic             fetch;
  logic             enq;
  logic             deq;
  logic             not_empty;

  // Occupancy counts the in-flight word but not a same-cycle dequeue, so the FIFO never overflows.
  assign pending   = {1'b0, count_r} + {{CNT_W{1'b0}}, req_q};
  assign fetch     = rst_n & ~qif.flush & (pending < (CNT_W+1)'(DEPTH));
  assign not_empty = (count_r != '0);
  assign enq       = req_q & ~qif.flush;
  assign deq       = not_empty & ~qif.stall & ~qif.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pc_q    <= RESET_PC;
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      req_q   <= 1'b0;
    end else if (qif.flush) begin
      pc      <= qif.redirect_pc;
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= fetch;
      if (fetch) begin
        pc   <= pc + 32'd4;
        pc_q <= pc;
      end
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      instr_mem[tail] <= qif.imem_data;
      pc_mem[tail]    <= pc_q;
    end
  end

  assign qif.imem_addr   = pc;
  assign qif.imem_req    = fetch;
  assign qif.instr_valid = not_empty;
  assign qif.instruction = not_empty ? instr_mem[head] : 32'h0;
  assign qif.instr_pc    = not_empty ? pc_mem[head]    : 32'h0;
  assign qif.count       = count_r;
  assign qif.full        = (count_r == CNT_W'(DEPTH));

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a stimulus table for streaming, stall, flush and PC wrap, then
// hand-written sequences for async reset, fill/refill and flush with a fetch in flight.
module tb_instr_queue;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  instr_queue_if #(.DEPTH(DEPTH)) qif ();

  instr_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .qif   (qif.master)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [3:0]  e_count;
    logic        e_full;
  } vec_t;

  int vectors_applied = 0;
  int miscompares     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word is the address plus a marker, returned one cycle after the request.
  always @(posedge clk) begin
    if (qif.imem_req) qif.imem_data <= qif.imem_addr + 32'h1000_0000;
  end

  task automatic apply_stimulus(input logic r, input logic s, input logic f, input logic [31:0] redir);
    @(negedge clk);
    rst_n           = r;
    qif.stall       = s;
    qif.flush       = f;
    qif.redirect_pc = redir;
    #1;
  endtask

  task automatic check_output(input string name, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic [3:0] e_count, input logic e_full);
    vectors_applied++;
    if (qif.imem_req !== e_req || qif.imem_addr !== e_addr || qif.instr_valid !== e_valid ||
        qif.instruction !== e_instr || qif.instr_pc !== e_pc || qif.count !== e_count ||
        qif.full !== e_full) begin
      miscompares++;
      $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h count=%0d full=%0b; want req=%0b addr=%h valid=%0b instr=%h pc=%h count=%0d full=%0b",
               name, qif.imem_req, qif.imem_addr, qif.instr_valid, qif.instruction, qif.instr_pc,
               qif.count, qif.full, e_req, e_addr, e_valid, e_instr, e_pc, e_count, e_full);
    end
  endtask

  vec_t vecs [18];

  initial begin
    rst_n           = 1'b0;
    qif.stall       = 1'b0;
    qif.flush       = 1'b0;
    qif.redirect_pc = 32'h0;
    qif.imem_data   = 32'h0;

    //              rst   stl   fl    redirect       req   addr           vld   instr          pc             cnt   full
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h1000_0000, 32'h0000_0000, 4'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h1000_0004, 32'h0000_0004, 4'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h1000_0008, 32'h0000_0008, 4'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h1000_000C, 32'h0000_000C, 4'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h1000_000C, 32'h0000_000C, 4'd2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b1, 32'h1000_000C, 32'h0000_000C, 4'd3, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0020, 1'b1, 32'h1000_0010, 32'h0000_0010, 4'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h1000_0100, 32'h0000_0100, 4'd1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_010C, 1'b1, 32'h1000_0104, 32'h0000_0104, 4'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         4'd0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0FFF_FFFC, 32'hFFFF_FFFC, 4'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h1000_0000, 32'h0000_0000, 4'd1, 1'b0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].redirect);
      check_output($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                   vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_count, vecs[i].e_full);
    end

    // Asynchronous reset between edges, then fill with stall held high.
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    qif.stall = 1'b1;
    #1;
    check_output("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("first_req_after_reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("fill_full", 1'b0, 32'h20, 1'b1, 32'h1000_0000, 32'h0, 4'd8, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("full_release", 1'b0, 32'h20, 1'b1, 32'h1000_0000, 32'h0, 4'd8, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("refill_req", 1'b1, 32'h20, 1'b1, 32'h1000_0004, 32'h4, 4'd7, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("refill_inflight", 1'b0, 32'h24, 1'b1, 32'h1000_0004, 32'h4, 4'd7, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("refill_full", 1'b0, 32'h24, 1'b1, 32'h1000_0004, 32'h4, 4'd8, 1'b1);

    // Flush while count is 5 with a fetch in flight.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("reset_again", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check_output("flush_cnt5", 1'b0, 32'h18, 1'b1, 32'h1000_0000, 32'h0, 4'd5, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("flush_clear", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("flush_no_stale", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("flush_redirect_head", 1'b1, 32'h108, 1'b1, 32'h1000_0100, 32'h100, 4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction fetch queue sitting directly upstream of the issue stage. It fetches 32-bit instructions from a synchronous instruction memory at sequential PCs and buffers them in a circular FIFO. It presents the head instruction and its PC to issue, and holds that instruction whenever issue raises `stall`. A branch/jump resolution `flush` empties the queue, squashes any in-flight fetch, and redirects the PC.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_addr`  out  32  fetch address; equals the internal PC.
- `imem_req`  out  1  fetch request this cycle (combinational).
- `imem_data`  in  32  instruction word; valid exactly one cycle after a request.
- `instruction`  out  32  head instruction; 32'h0 (NOP) when empty.
- `instr_pc`  out  32  PC of the head instruction; 32'h0 when empty.
- `instr_valid`  out  1  queue not empty.
- `stall`  in  1  issue cannot accept the head this cycle.
- `flush`  in  1  branch/jump redirect.
- `redirect_pc`  in  32  new fetch PC, sampled when `flush` is 1.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  `count == DEPTH`.

## Operation
- State: `pc`, `head`, `tail`, `count`, and `req_q` (a fetch is in flight). Each entry holds {instruction, pc}.
- Reset (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`; `head`=`tail`=`count`=0; `req_q`=0.
  - Outputs: `instruction`=0, `instr_pc`=0, `instr_valid`=0, `full`=0, `count`=0, `imem_req`=0 (gated by `rst_n`), `imem_addr`=`RESET_PC`.
- Fetch:
  - `imem_req = rst_n & ~flush & (count + req_q < DEPTH)`.
  - On a request: `pc <= pc + 4` (wraps modulo 2^32) and `req_q <= 1`; otherwise `req_q <= 0`.
  - An in-flight PC copy (`pc_q`) is captured alongside `req_q`.
- Enqueue: when `req_q`=1 and `flush`=0, write {`imem_data`, `pc_q`} at `tail` and increment `tail` modulo `DEPTH`.
- Dequeue: when `instr_valid`=1, `stall`=0 and `flush`=0, increment `head` modulo `DEPTH`.
- `count` update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both or neither occur.
- The occupancy check deliberately ignores a same-cycle dequeue (conservative). Overflow is therefore impossible, and underflow cannot occur because dequeue requires `instr_valid`.
- Flush has the highest priority. At the edge:
  - `head`=`tail`=`count`=0.
  - `req_q`=0, so the data returning next cycle is discarded.
  - `pc`=`redirect_pc`.
  - Enqueue and dequeue in the flush cycle are suppressed.
  - The first fetch from `redirect_pc` is issued the cycle after flush.
- `instruction`/`instr_pc` are read combinationally from `head` and forced to 0 when `count`=0.

## Timing
- Fetch-to-visible latency is 2 cycles:
  - Request in cycle N.
  - Data written at the end of cycle N+1.
  - `instr_valid`=1 in cycle N+2.
- After reset deassertion, the first request is in cycle 0 (addr `RESET_PC`) and the first `instr_valid` is in cycle 2.
- Streaming with `stall`=0 sustains 1 instruction/cycle.
- Held head: when `stall`=1, `instruction`/`instr_pc` are unchanged the next cycle.
- Fill limit with `stall` held at 1:
  - `imem_req` drops when `count + req_q == DEPTH`.
  - Steady state is `count`=`DEPTH`, `full`=1, `imem_req`=0.
- After the head is consumed from full, `count`=`DEPTH`-1. `imem_req` reasserts that cycle and the entry refills 1 cycle later.
- Flush-to-redirect latency:
  - Flush in cycle F; `instr_valid`=0 in F+1.
  - Request for `redirect_pc` in F+1; `instr_valid`=1 in F+3.
- Reset mid-operation: all state clears immediately (asynchronous). In-flight data is not written because `req_q` is cleared.

## Test plan
- Reset, `stall`=0, memory returns `addr`+32'h1000_0000 → requests at addresses 0, 4, 8. `instr_valid` rises in cycle 2 with `instruction`=32'h1000_0000, `instr_pc`=0; then one new word per cycle.
- `stall`=1 from reset → `count` reaches 8, `full`=1, `imem_req`=0. Release `stall` for one cycle → `count`=7, one new request, and `count` returns to 8 two cycles later.
- Flush with `redirect_pc`=32'h0000_0100 while `count`=5 and a fetch is in flight → next cycle `count`=0, `instr_valid`=0, `instruction`=0, in-flight word not written. Request at 0x100, and `instr_pc`=0x100 two cycles after that request.
- Flush asserted together with `stall`=0 and a valid head → head not dequeued, no enqueue, `count`=0 after the edge.
- PC wrap: `redirect_pc`=32'hFFFF_FFFC → requests at 0xFFFF_FFFC then 0x0000_0000, entries in order.
- Assert `rst_n`=0 mid-stream between clock edges → all outputs at reset values immediately, and the first request after release is at `RESET_PC`.
